// File: rtl/sparrow_pkg.sv
// Shared types and constants for the Sparrow write-back path.
package sparrow_pkg;

    localparam int SPARROW_NUM_WB_REQ = 3;

    localparam logic [4:0] SPARROW_REG_X0 = 5'd0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_req_t;

    // Successor of a requester index in a ring of n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sparrow_rr_arbiter.sv
// Generic N-way round-robin arbiter: pointer register plus one-hot grant.
module sparrow_rr_arbiter
    import sparrow_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic [N-1:0] i_valid,
    output logic [N-1:0] o_grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] next_ptr;
    logic [N-1:0]  grant_raw;
    logic          found;
    int            idx;

    // Scan upward from rr_ptr, wrapping; the inner loop keeps every select constant.
    always_comb begin
        grant_raw = '0;
        next_ptr  = rr_ptr;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            for (int j = 0; j < N; j++) begin
                if (!found && (j == idx) && i_valid[j]) begin
                    found        = 1'b1;
                    grant_raw[j] = 1'b1;
                    next_ptr     = PW'(rr_next(j, N));
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= next_ptr;
        end
    end

    assign o_grant = grant_raw & {N{i_reset_n}};

endmodule

// File: rtl/sparrow_wb_arbiter.sv
// Round-robin write-back arbiter driving the register file write port.
// Define SPARROW_WB_FWD_EN to add two forwarding ports off the staged write.
module sparrow_wb_arbiter
    import sparrow_pkg::*;
#(
    parameter int NUM_REQ = SPARROW_NUM_WB_REQ
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    output logic [NUM_REQ-1:0]      o_req_ready,
    input  logic [NUM_REQ*5-1:0]    i_req_addr,
    input  logic [NUM_REQ*32-1:0]   i_req_data,
`ifdef SPARROW_WB_FWD_EN
    input  logic [4:0]              i_fwd1_addr,
    input  logic [4:0]              i_fwd2_addr,
    output logic                    o_fwd1_hit,
    output logic                    o_fwd2_hit,
    output logic [31:0]             o_fwd1_data,
    output logic [31:0]             o_fwd2_data,
`endif
    output logic                    o_wr_en,
    output logic [4:0]              o_wr_addr,
    output logic [31:0]             o_wr_data,
    output logic                    o_busy
);

    logic [NUM_REQ-1:0] grant;
    logic               grant_any;
    wb_req_t            sel;

    sparrow_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (i_req_valid),
        .o_grant   (grant)
    );

    assign o_req_ready = grant;
    assign grant_any   = |grant;

    // Grant is one-hot, so an AND-OR mux picks the winning request.
    always_comb begin
        sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel.addr = i_req_addr[k*5 +: 5];
                sel.data = i_req_data[k*32 +: 32];
            end
        end
    end

    // x0 writes still load address/data but never raise the write enable.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
        end else begin
            o_wr_en <= grant_any && (sel.addr != SPARROW_REG_X0);
            if (grant_any) begin
                o_wr_addr <= sel.addr;
                o_wr_data <= sel.data;
            end
        end
    end

    assign o_busy = o_wr_en;

`ifdef SPARROW_WB_FWD_EN
    assign o_fwd1_hit  = o_wr_en && (o_wr_addr == i_fwd1_addr) && (i_fwd1_addr != SPARROW_REG_X0);
    assign o_fwd2_hit  = o_wr_en && (o_wr_addr == i_fwd2_addr) && (i_fwd2_addr != SPARROW_REG_X0);
    assign o_fwd1_data = o_wr_data;
    assign o_fwd2_data = o_wr_data;
`endif

endmodule

// File: tb/tb_sparrow_wb_arbiter.sv
// Self-checking bench for sparrow_wb_arbiter: directed scenarios plus a randomized run
// against a queue-free round-robin reference model.
module tb_sparrow_wb_arbiter;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*5-1:0]  req_addr = '0;
    logic [N*32-1:0] req_data = '0;
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [31:0]     wr_data;
    logic            busy;
`ifdef SPARROW_WB_FWD_EN
    logic [4:0]      fwd1_addr = '0;
    logic [4:0]      fwd2_addr = '0;
    logic            fwd1_hit;
    logic            fwd2_hit;
    logic [31:0]     fwd1_data;
    logic [31:0]     fwd2_data;
`endif

    int checks = 0;
    int errors = 0;

    sparrow_wb_arbiter #(
        .NUM_REQ (N)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
`ifdef SPARROW_WB_FWD_EN
        .i_fwd1_addr (fwd1_addr),
        .i_fwd2_addr (fwd2_addr),
        .o_fwd1_hit  (fwd1_hit),
        .o_fwd2_hit  (fwd2_hit),
        .o_fwd1_data (fwd1_data),
        .o_fwd2_data (fwd2_data),
`endif
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic clear_reqs();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    task automatic set_req(input int k, input logic [4:0] a, input logic [31:0] d);
        req_valid[k]        = 1'b1;
        req_addr[k*5 +: 5]  = a;
        req_data[k*32 +: 32] = d;
    endtask

    // Leaves the bench just after a clock edge with reset released and the pointer at 0.
    task automatic apply_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_reqs();
        set_req(0, 5'd9, 32'h1111_2222);
        reset_n = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %b expected 0", wr_en); end
        checks++; if (wr_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
        checks++; if (wr_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_wr_data: got %h expected 0", wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 000", req_ready); end
        @(posedge clk);
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_held_wr_en: got %b expected 0", wr_en); end
        reset_n = 1'b1;
        clear_reqs();
        #1;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("[TB] FAIL idle_ready: got %b expected 000", req_ready); end
        @(posedge clk);
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL idle_wr_en: got %b expected 0", wr_en); end
    endtask

    task automatic test_single();
        apply_reset();
        clear_reqs();
        set_req(1, 5'd5, 32'hDEAD_BEEF);
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("[TB] FAIL single_ready: got %b expected 010", req_ready); end
        @(posedge clk);
        #1;
        clear_reqs();
        checks++; if (wr_en !== 1'b1) begin errors++; $display("[TB] FAIL single_wr_en: got %b expected 1", wr_en); end
        checks++; if (wr_addr !== 5'd5) begin errors++; $display("[TB] FAIL single_wr_addr: got %0d expected 5", wr_addr); end
        checks++; if (wr_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL single_wr_data: got %h expected deadbeef", wr_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
        @(posedge clk);
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_wr_en: got %b expected 0", wr_en); end
        checks++; if (wr_addr !== 5'd5) begin errors++; $display("[TB] FAIL single_hold_addr: got %0d expected 5", wr_addr); end
        checks++; if (wr_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL single_hold_data: got %h expected deadbeef", wr_data); end
    endtask

    task automatic test_all_valid();
        logic [2:0] exp_ready;
        apply_reset();
        clear_reqs();
        for (int k = 0; k < N; k++) begin
            set_req(k, 5'(10 + k), 32'hC0DE_0000 + k);
        end
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            exp_ready = 3'b001 << (cyc % 3);
            checks++; if (req_ready !== exp_ready) begin errors++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", cyc, req_ready, exp_ready); end
            @(posedge clk);
            #1;
            checks++; if (wr_en !== 1'b1) begin errors++; $display("[TB] FAIL rr_wr_en[%0d]: got %b expected 1", cyc, wr_en); end
            checks++; if (wr_addr !== 5'(10 + cyc % 3)) begin errors++; $display("[TB] FAIL rr_wr_addr[%0d]: got %0d expected %0d", cyc, wr_addr, 10 + cyc % 3); end
            checks++; if (wr_data !== 32'hC0DE_0000 + 32'(cyc % 3)) begin errors++; $display("[TB] FAIL rr_wr_data[%0d]: got %h expected %h", cyc, wr_data, 32'hC0DE_0000 + 32'(cyc % 3)); end
        end
        clear_reqs();
        @(posedge clk);
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL rr_end_wr_en: got %b expected 0", wr_en); end
    endtask

    task automatic test_x0();
        apply_reset();
        clear_reqs();
        set_req(0, 5'd0, 32'h0000_1234);
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("[TB] FAIL x0_ready: got %b expected 001", req_ready); end
        @(posedge clk);
        #1;
        clear_reqs();
        checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL x0_wr_en: got %b expected 0", wr_en); end
        checks++; if (wr_addr !== 5'd0) begin errors++; $display("[TB] FAIL x0_wr_addr: got %0d expected 0", wr_addr); end
        checks++; if (wr_data !== 32'h0000_1234) begin errors++; $display("[TB] FAIL x0_wr_data: got %h expected 00001234", wr_data); end
        set_req(0, 5'd2, 32'h2);
        set_req(1, 5'd3, 32'h3);
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("[TB] FAIL x0_ptr_advance: got %b expected 010", req_ready); end
        @(posedge clk);
        #1;
        clear_reqs();
    endtask

    task automatic test_skip();
        apply_reset();
        clear_reqs();
        set_req(0, 5'd4, 32'h4);
        @(posedge clk);
        #1;
        clear_reqs();
        set_req(0, 5'd9, 32'h0000_0011);
        set_req(2, 5'd10, 32'h0000_0022);
        #1;
        checks++; if (req_ready !== 3'b100) begin errors++; $display("[TB] FAIL skip_first_ready: got %b expected 100", req_ready); end
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        checks++; if (wr_addr !== 5'd10) begin errors++; $display("[TB] FAIL skip_first_addr: got %0d expected 10", wr_addr); end
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("[TB] FAIL skip_second_ready: got %b expected 001", req_ready); end
        @(posedge clk);
        #1;
        clear_reqs();
        checks++; if (wr_addr !== 5'd9 || wr_data !== 32'h11) begin errors++; $display("[TB] FAIL skip_second_write: got %0d/%h expected 9/00000011", wr_addr, wr_data); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        clear_reqs();
        set_req(1, 5'd3, 32'h0000_CAFE);
        @(posedge clk);
        #1;
        clear_reqs();
        checks++; if (wr_en !== 1'b1) begin errors++; $display("[TB] FAIL mid_staged_wr_en: got %b expected 1", wr_en); end
        reset_n = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_drop: got %b/%b expected 0/0", wr_en, busy); end
        checks++; if (wr_addr !== 5'd0 || wr_data !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset_clear: got %0d/%h expected 0/0", wr_addr, wr_data); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_partial: got %b expected 0", wr_en); end
    endtask

`ifdef SPARROW_WB_FWD_EN
    task automatic test_fwd();
        apply_reset();
        clear_reqs();
        set_req(0, 5'd7, 32'hA5A5_A5A5);
        fwd1_addr = 5'd7;
        fwd2_addr = 5'd8;
        #1;
        checks++; if (fwd1_hit !== 1'b0) begin errors++; $display("[TB] FAIL fwd_early_hit: got %b expected 0", fwd1_hit); end
        @(posedge clk);
        #1;
        clear_reqs();
        checks++; if (fwd1_hit !== 1'b1) begin errors++; $display("[TB] FAIL fwd1_hit: got %b expected 1", fwd1_hit); end
        checks++; if (fwd1_data !== 32'hA5A5_A5A5) begin errors++; $display("[TB] FAIL fwd1_data: got %h expected a5a5a5a5", fwd1_data); end
        checks++; if (fwd2_hit !== 1'b0) begin errors++; $display("[TB] FAIL fwd2_hit: got %b expected 0", fwd2_hit); end
        fwd1_addr = 5'd0;
        fwd2_addr = 5'd7;
        #1;
        checks++; if (fwd1_hit !== 1'b0) begin errors++; $display("[TB] FAIL fwd1_x0_hit: got %b expected 0", fwd1_hit); end
        checks++; if (fwd2_hit !== 1'b1 || fwd2_data !== 32'hA5A5_A5A5) begin errors++; $display("[TB] FAIL fwd2_match: got %b/%h expected 1/a5a5a5a5", fwd2_hit, fwd2_data); end
        set_req(1, 5'd0, 32'h5);
        @(posedge clk);
        #1;
        clear_reqs();
        checks++; if (fwd1_hit !== 1'b0) begin errors++; $display("[TB] FAIL fwd_x0_write_hit: got %b expected 0", fwd1_hit); end
        @(posedge clk);
        #1;
    endtask
`endif

    // Reference model: pending requests per requester, a ring pointer, and the staged write.
    task automatic test_random();
        bit          m_valid [N];
        logic [4:0]  m_addr  [N];
        logic [31:0] m_data  [N];
        int          m_ptr;
        int          winner;
        logic [N-1:0] exp_ready;
        logic        exp_en;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        int          grants [N];
        apply_reset();
        clear_reqs();
        m_ptr    = 0;
        exp_addr = '0;
        exp_data = '0;
        for (int k = 0; k < N; k++) begin
            m_valid[k] = 1'b0;
            m_addr[k]  = '0;
            m_data[k]  = '0;
            grants[k]  = 0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (!m_valid[k] && $urandom_range(0, 9) < 6) begin
                    m_valid[k] = 1'b1;
                    m_addr[k]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    m_data[k]  = $urandom;
                end
                req_valid[k]         = m_valid[k];
                req_addr[k*5 +: 5]   = m_addr[k];
                req_data[k*32 +: 32] = m_data[k];
            end
            winner = -1;
            for (int i = 0; i < N; i++) begin
                int cand;
                cand = (m_ptr + i) % N;
                if (winner < 0 && m_valid[cand]) winner = cand;
            end
            exp_ready = '0;
            if (winner >= 0) exp_ready[winner] = 1'b1;
            #1;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", cyc, req_ready, exp_ready); end
            @(posedge clk);
            if (winner >= 0) begin
                exp_en          = (m_addr[winner] != 5'd0);
                exp_addr        = m_addr[winner];
                exp_data        = m_data[winner];
                m_valid[winner] = 1'b0;
                m_ptr           = (winner + 1) % N;
                grants[winner]++;
            end else begin
                exp_en = 1'b0;
            end
            #1;
            checks++; if (wr_en !== exp_en || busy !== exp_en) begin errors++; $display("[TB] FAIL rand_wr_en[%0d]: got %b/%b expected %b", cyc, wr_en, busy, exp_en); end
            checks++; if (wr_addr !== exp_addr || wr_data !== exp_data) begin errors++; $display("[TB] FAIL rand_wr_payload[%0d]: got %0d/%h expected %0d/%h", cyc, wr_addr, wr_data, exp_addr, exp_data); end
        end
        clear_reqs();
        $display("[TB] random grants: %0d %0d %0d", grants[0], grants[1], grants[2]);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_all_valid();
        test_x0();
        test_skip();
        test_reset_mid();
`ifdef SPARROW_WB_FWD_EN
        test_fwd();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
